// File: rtl/lzc_pkg.sv
// Shared types and constants for the LZC operand driver.
package lzc_pkg;

    // Width of the LZC leading-zero count.
    localparam int ZW = 6;

    // Driver FSM states.
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RESP
    } lzc_drv_state_t;

endpackage

// File: rtl/lzc_driver.sv
// Operand-side driver for the LZC leading-zero counter: accepts a full operand,
// streams it MSB word first, then captures the count (or times out) and returns it.
module lzc_driver
    import lzc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int WORD    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [WIDTH*WORD-1:0]  IN_OPERAND,
    output logic                   MODE,
    output logic                   IVALID,
    output logic [WIDTH-1:0]       DATA,
    input  logic                   OVALID,
    input  logic [ZW-1:0]          ZEROS,
    output logic                   RES_VALID,
    input  logic                   RES_READY,
    output logic [ZW-1:0]          RES_ZEROS,
    output logic                   RES_TIMEOUT
);

    localparam int OPW = WIDTH * WORD;
    localparam int WCW = (WORD > 1) ? $clog2(WORD) : 1;
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORD - 1);
    localparam logic [TCW-1:0] TMO_END   = TCW'(TIMEOUT);

    lzc_drv_state_t state;
    logic [OPW-1:0] shreg;
    logic [WCW-1:0] word_cnt;
    logic [TCW-1:0] tmo_cnt;
    logic           got;
    logic [ZW-1:0]  cap_zeros;

    logic [TCW-1:0]   tmo_next;
    logic [WIDTH-1:0] next_word;

    // Timeout counter increment and the next word waiting in the shift register.
    always_comb begin
        tmo_next  = tmo_cnt + 1'b1;
        next_word = shreg[OPW-1 -: WIDTH];
    end

    // Driver FSM with registered outputs; reset abandons any operand in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            shreg       <= '0;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            got         <= 1'b0;
            cap_zeros   <= '0;
            IN_READY    <= 1'b0;
            MODE        <= 1'b0;
            IVALID      <= 1'b0;
            DATA        <= '0;
            RES_VALID   <= 1'b0;
            RES_ZEROS   <= '0;
            RES_TIMEOUT <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    IN_READY <= 1'b1;
                    MODE     <= 1'b0;
                    IVALID   <= 1'b0;
                    DATA     <= '0;
                    if (IN_VALID && IN_READY) begin
                        // Word 0 goes out straight from the operand so it appears
                        // in the cycle right after acceptance.
                        IN_READY <= 1'b0;
                        MODE     <= 1'b1;
                        IVALID   <= 1'b1;
                        DATA     <= IN_OPERAND[OPW-1 -: WIDTH];
                        shreg    <= IN_OPERAND << WIDTH;
                        word_cnt <= '0;
                        tmo_cnt  <= '0;
                        got      <= 1'b0;
                        state    <= SEND;
                    end
                end

                SEND: begin
                    // Only the first result for this operand is kept.
                    if (OVALID && !got) begin
                        got       <= 1'b1;
                        cap_zeros <= ZEROS;
                    end
                    MODE <= 1'b0;
                    if (word_cnt == LAST_WORD) begin
                        IVALID <= 1'b0;
                        DATA   <= '0;
                        if (got || OVALID) begin
                            RES_VALID   <= 1'b1;
                            RES_TIMEOUT <= 1'b0;
                            RES_ZEROS   <= got ? cap_zeros : ZEROS;
                            state       <= RESP;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= WAIT;
                        end
                    end else begin
                        DATA     <= next_word;
                        shreg    <= shreg << WIDTH;
                        word_cnt <= word_cnt + 1'b1;
                    end
                end

                WAIT: begin
                    MODE   <= 1'b0;
                    IVALID <= 1'b0;
                    DATA   <= '0;
                    // A result arriving on the expiry cycle still counts as an answer.
                    if (OVALID) begin
                        RES_VALID   <= 1'b1;
                        RES_TIMEOUT <= 1'b0;
                        RES_ZEROS   <= ZEROS;
                        state       <= RESP;
                    end else if (tmo_next == TMO_END) begin
                        tmo_cnt     <= tmo_next;
                        RES_VALID   <= 1'b1;
                        RES_TIMEOUT <= 1'b1;
                        RES_ZEROS   <= '0;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end

                RESP: begin
                    if (RES_READY) begin
                        RES_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_driver.sv
// Bench for lzc_driver: behavioural LZC partner with selectable stub modes and
// randomized operands/latencies checked against a leading-zero reference.
module tb_lzc_driver;
    import lzc_pkg::*;

    localparam int WIDTH   = 4;
    localparam int WORD    = 4;
    localparam int TIMEOUT = 16;
    localparam int OPW     = WIDTH * WORD;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [OPW-1:0]   IN_OPERAND = '0;
    logic             MODE;
    logic             IVALID;
    logic [WIDTH-1:0] DATA;
    logic             OVALID;
    logic [ZW-1:0]    ZEROS;
    logic             RES_VALID;
    logic             RES_READY = 1'b0;
    logic [ZW-1:0]    RES_ZEROS;
    logic             RES_TIMEOUT;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int stub  = 0;   // 0: normal LZC, 1: silent, 2: early + duplicate pulses
    int lat   = 0;   // extra response latency of the normal LZC

    lzc_driver #(
        .WIDTH   (WIDTH),
        .WORD    (WORD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_OPERAND  (IN_OPERAND),
        .MODE        (MODE),
        .IVALID      (IVALID),
        .DATA        (DATA),
        .OVALID      (OVALID),
        .ZEROS       (ZEROS),
        .RES_VALID   (RES_VALID),
        .RES_READY   (RES_READY),
        .RES_ZEROS   (RES_ZEROS),
        .RES_TIMEOUT (RES_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int lz_ref(input logic [OPW-1:0] v);
        for (int i = OPW - 1; i >= 0; i--) begin
            if (v[i]) return OPW - 1 - i;
        end
        return OPW;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // LZC partner: collects words, answers after the last one.
    logic [OPW-1:0] lzc_buf;
    int             lzc_cnt;
    logic           lzc_last;
    int             pend;
    logic [ZW-1:0]  pend_z;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            lzc_buf  <= '0;
            lzc_cnt  <= 0;
            lzc_last <= 1'b0;
        end else begin
            lzc_last <= 1'b0;
            if (IVALID) begin
                lzc_buf <= {lzc_buf[OPW-WIDTH-1:0], DATA};
                if (MODE) begin
                    lzc_cnt  <= 1;
                    lzc_last <= (WORD == 1);
                end else begin
                    lzc_cnt  <= lzc_cnt + 1;
                    lzc_last <= (lzc_cnt + 1 == WORD);
                end
            end
        end
    end

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVALID <= 1'b0;
            ZEROS  <= '0;
            pend   <= -1;
            pend_z <= '0;
        end else begin
            OVALID <= 1'b0;
            if (IVALID && MODE) pend <= -1;
            if (stub == 2 && IVALID && !MODE && lzc_cnt == 1) begin
                OVALID <= 1'b1;
                ZEROS  <= ZW'(5);
            end else if (stub == 2 && IVALID && !MODE && lzc_cnt == 2) begin
                OVALID <= 1'b1;
                ZEROS  <= ZW'(9);
            end else if (stub == 2 && lzc_last) begin
                OVALID <= 1'b1;
                ZEROS  <= ZW'(9);
            end else if (stub == 0 && lzc_last) begin
                if (lat == 0) begin
                    OVALID <= 1'b1;
                    ZEROS  <= ZW'(lz_ref(lzc_buf));
                end else begin
                    pend   <= lat;
                    pend_z <= ZW'(lz_ref(lzc_buf));
                end
            end else if (pend == 1) begin
                OVALID <= 1'b1;
                ZEROS  <= pend_z;
                pend   <= -1;
            end else if (pend > 1) begin
                pend <= pend - 1;
            end
        end
    end

    // Expect the operand's words MSB first, MODE only on word 0.
    task automatic check_words(input logic [OPW-1:0] op);
        logic [OPW-1:0] w;
        for (int k = 0; k < WORD; k++) begin
            @(negedge CLK);
            w = (op >> (WIDTH * (WORD - 1 - k))) & ((1 << WIDTH) - 1);
            check_val("data", DATA, w);
            check_val("mode", MODE, (k == 0));
            check_val("ivalid", IVALID, 1);
        end
    endtask

    task automatic start_op(input logic [OPW-1:0] op, output int acc);
        int waited = 0;
        @(negedge CLK);
        IN_OPERAND = op;
        IN_VALID   = 1'b1;
        while (!IN_READY && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        check_val("in_ready_accept", IN_READY, 1);
        @(posedge CLK);
        #1;
        acc      = cyc;
        IN_VALID = 1'b0;
        check_words(op);
    endtask

    task automatic finish_op(input int exp_z, input int exp_to, input int exp_cyc, input bit hs);
        int n = 0;
        @(negedge CLK);
        check_val("ivalid_drop", IVALID, 0);
        while (!RES_VALID && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check_val("res_valid", RES_VALID, 1);
        check_val("res_cycle", cyc, exp_cyc);
        check_val("res_zeros", RES_ZEROS, exp_z);
        check_val("res_timeout", RES_TIMEOUT, exp_to);
        check_val("in_ready_busy", IN_READY, 0);
        if (hs) begin
            RES_READY = 1'b1;
            @(posedge CLK);
            #1;
            RES_READY = 1'b0;
            @(negedge CLK);
            check_val("res_valid_drop", RES_VALID, 0);
            check_val("in_ready_back", IN_READY, 1);
        end
    endtask

    // Normal LZC with a given latency; a reply later than the window times out.
    task automatic do_normal(input logic [OPW-1:0] op, input int l);
        int acc;
        int last;
        bit to;
        stub = 0;
        lat  = l;
        start_op(op, acc);
        last = acc + WORD - 1;
        to   = (l > TIMEOUT - 2);
        finish_op(to ? 0 : lz_ref(op), to, to ? last + TIMEOUT + 1 : last + 3 + l, 1'b1);
    endtask

    initial begin
        int acc;
        logic [OPW-1:0] op;
        logic [OPW-1:0] op2;

        // Reset state.
        repeat (3) @(negedge CLK);
        check_val("rst_in_ready", IN_READY, 0);
        check_val("rst_ivalid", IVALID, 0);
        check_val("rst_mode", MODE, 0);
        check_val("rst_data", DATA, 0);
        check_val("rst_res_valid", RES_VALID, 0);
        check_val("rst_res_zeros", RES_ZEROS, 0);
        check_val("rst_res_timeout", RES_TIMEOUT, 0);
        RST = 1'b0;
        @(negedge CLK);
        check_val("post_rst_in_ready", IN_READY, 1);

        // Basic stream and edge operands.
        do_normal(16'h00B3, 0);
        do_normal(16'h0000, 0);
        do_normal(16'h8000, 0);
        do_normal(16'h0001, 3);

        // Result on the expiry cycle wins; one cycle later times out.
        do_normal(16'h0700, TIMEOUT - 2);
        do_normal(16'h0700, TIMEOUT - 1);

        // Silent LZC: timeout.
        stub = 1;
        start_op(16'h1234, acc);
        finish_op(0, 1, acc + WORD - 1 + TIMEOUT + 1, 1'b1);

        // Early and duplicate OVALID.
        stub = 2;
        start_op(16'h3C5A, acc);
        finish_op(5, 0, acc + WORD, 1'b1);
        check_val("all_words_sent", lzc_buf, 16'h3C5A);
        stub = 0;

        // Backpressure with the next operand already offered.
        lat = 0;
        op  = 16'h0123;
        op2 = 16'h4000;
        start_op(op, acc);
        finish_op(lz_ref(op), 0, acc + WORD - 1 + 3, 1'b0);
        IN_OPERAND = op2;
        IN_VALID   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_val("bp_res_valid", RES_VALID, 1);
            check_val("bp_res_zeros", RES_ZEROS, lz_ref(op));
            check_val("bp_res_timeout", RES_TIMEOUT, 0);
            check_val("bp_in_ready", IN_READY, 0);
            check_val("bp_mode", MODE, 0);
        end
        RES_READY = 1'b1;
        @(posedge CLK);
        #1;
        RES_READY = 1'b0;
        @(negedge CLK);
        check_val("bp_mode_after_hs", MODE, 0);
        check_val("bp_in_ready_after_hs", IN_READY, 1);
        @(posedge CLK);
        #1;
        acc      = cyc;
        IN_VALID = 1'b0;
        check_words(op2);
        finish_op(lz_ref(op2), 0, acc + WORD - 1 + 3, 1'b1);

        // Reset during word 1.
        @(negedge CLK);
        IN_OPERAND = 16'hFFFF;
        IN_VALID   = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        @(posedge CLK);
        #2;
        check_val("pre_rst_ivalid", IVALID, 1);
        RST = 1'b1;
        #1;
        check_val("midrst_ivalid", IVALID, 0);
        check_val("midrst_mode", MODE, 0);
        check_val("midrst_res_valid", RES_VALID, 0);
        check_val("midrst_in_ready", IN_READY, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_val("midrst_in_ready_back", IN_READY, 1);
        do_normal(16'h0F00, 0);

        // Randomized operands and latencies.
        for (int i = 0; i < 24; i++) begin
            op = OPW'($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) do_normal(op, $urandom_range(10, 15));
            else                           do_normal(op, $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
